iob_ethmac_mem_arbiter: RTL

- Two-requester IOb arbiter sharing one IOb memory port between the ethmac DMA master (requester 0) and a host/CPU master (requester 1), e.g. for host access to the buffer memory.
- Round-robin, one outstanding transaction, registered downstream request.
- Sits between iob_ethmac's m_* port and iob_iob2wishbone (or native memory).

---
 rtl/iob_ethmac_mem_arbiter_pkg.sv | 22 ++
 rtl/iob_ethmac_mem_arbiter_if.sv | 25 ++
 rtl/iob_ethmac_mem_arbiter_rr_pick2.sv | 24 ++
 rtl/iob_ethmac_mem_arbiter.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/iob_ethmac_mem_arbiter_pkg.sv
// Shared definitions for the iob_ethmac memory arbiter family.
// Holds the arbiter state encoding, requester indices and the fill value
// returned to a requester whose transaction is cut short by the watchdog.
package iob_ethmac_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Requester indices; with two requesters a single bit identifies the owner
    localparam logic REQ_DMA  = 1'b0;
    localparam logic REQ_HOST = 1'b1;

    // Every rdata bit is driven to this value on a watchdog completion
    localparam logic TIMEOUT_FILL = 1'b1;

    function automatic logic [1:0] req_onehot(input logic idx);
        return (idx == REQ_HOST) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/iob_ethmac_mem_arbiter_if.sv
// IOb bus bundle used by the arbiter ports.
// The master drives the request fields, the slave answers with rdata/ready.
interface iob_ethmac_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic                  valid;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic [DATA_W-1:0]     rdata;
    logic                  ready;

    modport master (
        output valid, addr, wdata, wstrb,
        input  rdata, ready
    );

    modport slave (
        input  valid, addr, wdata, wstrb,
        output rdata, ready
    );

endinterface

// File: rtl/iob_ethmac_mem_arbiter_rr_pick2.sv
// Two-way round-robin pick. Purely combinational so other arbiters can reuse it:
// a lone valid wins outright, a tie goes to whoever did not own the bus last.
module iob_ethmac_rr_pick2
    import iob_ethmac_pkg::*;
(
    input  logic valid0,
    input  logic valid1,
    input  logic last_owner,
    output logic winner,
    output logic any_valid
);

    // Resolve the winner index from the two requests and the previous owner
    always_comb begin
        any_valid = valid0 | valid1;
        winner    = REQ_DMA;
        if (valid0 && valid1) begin
            winner = ~last_owner;
        end else if (valid1) begin
            winner = REQ_HOST;
        end
    end

endmodule

// File: rtl/iob_ethmac_mem_arbiter.sv
// Two-requester IOb arbiter: ethmac DMA (r0) and host (r1) share one memory port.
// Round-robin, one outstanding transaction, registered downstream request.
// Optional watchdog enabled by defining IOB_ETHMAC_ARB_TIMEOUT_EN: a stuck memory
// completes the transaction with all-ones rdata and raises the sticky err_o.
module iob_ethmac_mem_arbiter
    import iob_ethmac_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    iob_ethmac_mem_arbiter_if.slave   r0,
    iob_ethmac_mem_arbiter_if.slave   r1,
    iob_ethmac_mem_arbiter_if.master  m,
    output logic [1:0]                grant_o,
    output logic                      err_o
);

    if (TIMEOUT_W < 1) begin : g_timeout_w_check
        $error("TIMEOUT_W must be at least 1");
    end

    state_t              state_q;
    state_t              state_d;
    logic                owner_q;
    logic                last_owner_q;
    logic                m_valid_q;
    logic [ADDR_W-1:0]   m_addr_q;
    logic [DATA_W-1:0]   m_wdata_q;
    logic [DATA_W/8-1:0] m_wstrb_q;
    logic [1:0]          grant_q;

    logic                winner;
    logic                any_valid;
    logic                grant_take;
    logic                complete;
    logic                to_hit;
    logic [DATA_W-1:0]   resp_data;
    logic                r0_hit;
    logic                r1_hit;

    iob_ethmac_rr_pick2 u_pick (
        .valid0     (r0.valid),
        .valid1     (r1.valid),
        .last_owner (last_owner_q),
        .winner     (winner),
        .any_valid  (any_valid)
    );

`ifdef IOB_ETHMAC_ARB_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] timer_q;
    logic                 err_q;

    // Watchdog fires when the busy timer saturates and memory still has not answered
    always_comb begin
        to_hit = (state_q == BUSY) && !m.ready && (timer_q == {TIMEOUT_W{1'b1}});
    end

    // Watchdog counter restarts on every grant and counts unanswered busy cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q <= '0;
        end else if (grant_take) begin
            timer_q <= '0;
        end else if ((state_q == BUSY) && !m.ready && !to_hit) begin
            timer_q <= timer_q + 1'b1;
        end
    end

    // Error flag stays set until the next reset
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (to_hit) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign to_hit = 1'b0;
    assign err_o  = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: grant from IDLE, finish BUSY on m_ready (or watchdog)
    always_comb begin
        state_d    = state_q;
        grant_take = 1'b0;
        complete   = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    state_d    = BUSY;
                    grant_take = 1'b1;
                end
            end
            BUSY: begin
                if (m.ready || to_hit) begin
                    state_d  = IDLE;
                    complete = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Latch the winner's request on grant and clear everything on completion
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q      <= REQ_DMA;
            last_owner_q <= REQ_HOST;
            m_valid_q    <= 1'b0;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
            m_wstrb_q    <= '0;
            grant_q      <= 2'b00;
        end else if (grant_take) begin
            owner_q   <= winner;
            m_valid_q <= 1'b1;
            grant_q   <= req_onehot(winner);
            if (winner == REQ_HOST) begin
                m_addr_q  <= r1.addr;
                m_wdata_q <= r1.wdata;
                m_wstrb_q <= r1.wstrb;
            end else begin
                m_addr_q  <= r0.addr;
                m_wdata_q <= r0.wdata;
                m_wstrb_q <= r0.wstrb;
            end
        end else if (complete) begin
            last_owner_q <= owner_q;
            m_valid_q    <= 1'b0;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
            m_wstrb_q    <= '0;
            grant_q      <= 2'b00;
        end
    end

    // Route the completion back to the owner only; rdata is zero unless ready
    always_comb begin
        resp_data = to_hit ? {DATA_W{TIMEOUT_FILL}} : m.rdata;
        r0_hit    = complete && (owner_q == REQ_DMA);
        r1_hit    = complete && (owner_q == REQ_HOST);
    end

    assign r0.ready = r0_hit;
    assign r0.rdata = r0_hit ? resp_data : '0;
    assign r1.ready = r1_hit;
    assign r1.rdata = r1_hit ? resp_data : '0;

    assign m.valid  = m_valid_q;
    assign m.addr   = m_addr_q;
    assign m.wdata  = m_wdata_q;
    assign m.wstrb  = m_wstrb_q;
    assign grant_o  = grant_q;

endmodule
